// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS pipeline.
// Owns the PC, talks to a wait-stated instruction memory and buffers data caught by a stall.
module if_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [ADDR_W-1:0] if_id_pc_o,
    output logic [ADDR_W-1:0] if_id_pc4_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_valid_o,
    output logic              fetch_busy_o
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HELD  = 1'b1
    } fetchState_t;

    fetchState_t       state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [ADDR_W-1:0] ifIdPc, ifIdPcNext;
    logic [ADDR_W-1:0] ifIdPc4, ifIdPc4Next;
    logic [31:0]       ifIdInstr, ifIdInstrNext;
    logic              ifIdValid, ifIdValidNext;
    logic [31:0]       holdBuf, holdBufNext;

    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] alignedTarget;

    assign pcPlus4       = pc + ADDR_W'(4);
    // Word-align the redirect; the low two address bits are never meaningful.
    assign alignedTarget = branch_target_i & ~ADDR_W'(3);

    assign imem_req_o    = (state == S_FETCH) && !rst_i;
    assign imem_addr_o   = pc;
    assign fetch_busy_o  = imem_req_o && !imem_ready_i;

    assign if_id_pc_o    = ifIdPc;
    assign if_id_pc4_o   = ifIdPc4;
    assign if_id_instr_o = ifIdInstr;
    assign if_id_valid_o = ifIdValid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ifIdPc    <= '0;
            ifIdPc4   <= '0;
            ifIdInstr <= '0;
            ifIdValid <= 1'b0;
            holdBuf   <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            ifIdPc    <= ifIdPcNext;
            ifIdPc4   <= ifIdPc4Next;
            ifIdInstr <= ifIdInstrNext;
            ifIdValid <= ifIdValidNext;
            holdBuf   <= holdBufNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        ifIdPcNext    = ifIdPc;
        ifIdPc4Next   = ifIdPc4;
        ifIdInstrNext = ifIdInstr;
        ifIdValidNext = ifIdValid;
        holdBufNext   = holdBuf;

        unique case (state)
            S_FETCH: begin
                if (flush_i) begin
                    pcNext        = alignedTarget;
                    ifIdValidNext = 1'b0;
                end else if (stall_i) begin
                    // Data arriving under a stall is parked so the access isn't repeated.
                    if (imem_ready_i) begin
                        holdBufNext = imem_rdata_i;
                        stateNext   = S_HELD;
                    end
                end else if (imem_ready_i) begin
                    ifIdPcNext    = pc;
                    ifIdPc4Next   = pcPlus4;
                    ifIdInstrNext = imem_rdata_i;
                    ifIdValidNext = 1'b1;
                    pcNext        = pcPlus4;
                end else begin
                    ifIdValidNext = 1'b0;
                end
            end
            S_HELD: begin
                if (flush_i) begin
                    holdBufNext   = '0;
                    pcNext        = alignedTarget;
                    ifIdValidNext = 1'b0;
                    stateNext     = S_FETCH;
                end else if (!stall_i) begin
                    ifIdPcNext    = pc;
                    ifIdPc4Next   = pcPlus4;
                    ifIdInstrNext = holdBuf;
                    ifIdValidNext = 1'b1;
                    pcNext        = pcPlus4;
                    stateNext     = S_FETCH;
                end
            end
            default: stateNext = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, wait states, stall buffering, flushes,
// PC wrap-around and reset while a stalled instruction is held.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPc4;
    logic [31:0] ifIdInstr;
    logic        ifIdValid;
    logic        fetchBusy;

    logic        dataOverride;
    logic [31:0] overrideVal;

    int unsigned checkCount = 0;
    int unsigned passCount  = 0;

    always #5 clk = ~clk;

    // Memory model: data is a fixed function of the address unless overridden.
    assign imemRdata = dataOverride ? overrideVal : (imemAddr ^ 32'hA5A5_0000);

    if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (branchTarget),
        .imem_req_o      (imemReq),
        .imem_addr_o     (imemAddr),
        .imem_ready_i    (imemReady),
        .imem_rdata_i    (imemRdata),
        .if_id_pc_o      (ifIdPc),
        .if_id_pc4_o     (ifIdPc4),
        .if_id_instr_o   (ifIdInstr),
        .if_id_valid_o   (ifIdValid),
        .fetch_busy_o    (fetchBusy)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                             input logic [31:0] instr);
        checkVal({tag, ".pc"},    ifIdPc,    pc);
        checkVal({tag, ".pc4"},   ifIdPc4,   pc4);
        checkVal({tag, ".instr"}, ifIdInstr, instr);
        checkVal({tag, ".valid"}, {31'b0, ifIdValid}, 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; imemReady = 1'b0;
        branchTarget = '0; dataOverride = 1'b0; overrideVal = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; imemReady = 1'b1;
        branchTarget = '0; dataOverride = 1'b0; overrideVal = '0;
        #2;
        checkVal("rstReqComb", {31'b0, imemReq}, 32'd0);
        tick();
        tick();
        checkVal("rstValid", {31'b0, ifIdValid}, 32'd0);
        checkVal("rstPc",    ifIdPc,    32'd0);
        checkVal("rstPc4",   ifIdPc4,   32'd0);
        checkVal("rstInstr", ifIdInstr, 32'd0);
        checkVal("rstAddr",  imemAddr,  32'd0);

        // Zero-wait streaming: one instruction per cycle.
        rst = 1'b0;
        #1;
        checkVal("streamReq", {31'b0, imemReq}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkIfId("stream", 32'(4 * k), 32'(4 * k + 4), 32'(4 * k) ^ 32'hA5A5_0000);
        end
        checkVal("streamAddr", imemAddr, 32'h10);

        // Two wait states per fetch: valid pattern 0,0,1.
        for (int j = 0; j < 2; j++) begin
            for (int w = 0; w < 2; w++) begin
                imemReady = 1'b0;
                #1;
                checkVal("waitBusy", {31'b0, fetchBusy}, 32'd1);
                checkVal("waitAddr", imemAddr, 32'(32'h10 + 4 * j));
                tick();
                checkVal("waitValid", {31'b0, ifIdValid}, 32'd0);
            end
            imemReady = 1'b1;
            #1;
            checkVal("readyBusy", {31'b0, fetchBusy}, 32'd0);
            tick();
            checkIfId("waitDeliver", 32'(32'h10 + 4 * j), 32'(32'h14 + 4 * j),
                      32'(32'h10 + 4 * j) ^ 32'hA5A5_0000);
        end

        // Stall arriving with returned data at pc=8.
        doReset();
        imemReady = 1'b1;
        tick();
        tick();
        checkVal("preStallAddr", imemAddr, 32'h8);
        dataOverride = 1'b1; overrideVal = 32'h8C01_0004; stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            if (s == 0) dataOverride = 1'b0;
            checkIfId("stallHold", 32'h4, 32'h8, 32'hA5A5_0004);
            checkVal("stallReq", {31'b0, imemReq}, 32'd0);
        end
        stall = 1'b0;
        tick();
        checkIfId("stallRelease", 32'h8, 32'hC, 32'h8C01_0004);
        checkVal("stallNextAddr", imemAddr, 32'hC);
        checkVal("stallNextReq", {31'b0, imemReq}, 32'd1);

        // Flush beats stall in S_FETCH; returned data discarded.
        stall = 1'b1; flush = 1'b1; branchTarget = 32'h0000_0103;
        tick();
        checkVal("flushValid", {31'b0, ifIdValid}, 32'd0);
        checkVal("flushAddr",  imemAddr, 32'h100);
        checkVal("flushReq",   {31'b0, imemReq}, 32'd1);
        stall = 1'b0; flush = 1'b0;
        tick();
        checkIfId("flushDeliver", 32'h100, 32'h104, 32'hA5A5_0100);

        // Flush in S_HELD drops the buffered instruction.
        stall = 1'b1;
        tick();
        checkVal("heldReq", {31'b0, imemReq}, 32'd0);
        stall = 1'b0; flush = 1'b1; branchTarget = 32'h0000_0200;
        tick();
        checkVal("heldFlushValid", {31'b0, ifIdValid}, 32'd0);
        checkVal("heldFlushAddr",  imemAddr, 32'h200);
        flush = 1'b0;
        tick();
        checkIfId("heldFlushDeliver", 32'h200, 32'h204, 32'hA5A5_0200);

        // PC wrap-around.
        flush = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick();
        checkVal("wrapAddr", imemAddr, 32'hFFFF_FFFC);
        flush = 1'b0;
        tick();
        checkIfId("wrap", 32'hFFFF_FFFC, 32'h0, 32'h5A5A_FFFC);
        checkVal("wrapNextAddr", imemAddr, 32'h0);

        // Reset while held under a stall.
        stall = 1'b1;
        tick();
        checkVal("preRstHeldReq", {31'b0, imemReq}, 32'd0);
        rst = 1'b1;
        #1;
        checkVal("rstHeldReqComb", {31'b0, imemReq}, 32'd0);
        tick();
        checkVal("rstHeldValid", {31'b0, ifIdValid}, 32'd0);
        checkVal("rstHeldAddr",  imemAddr, 32'h0);
        checkVal("rstHeldReq",   {31'b0, imemReq}, 32'd0);
        rst = 1'b0; stall = 1'b0;
        #1;
        checkVal("postRstReq", {31'b0, imemReq}, 32'd1);
        tick();
        checkIfId("postRstDeliver", 32'h0, 32'h4, 32'hA5A5_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and issues requests to a wait-stated instruction memory.
- Presents {pc, pc+4, instr, valid} to the ID stage.
- Honours the load-use stall from hazard detection and the branch flush from ID; buffers a returned instruction when a stall arrives mid-fetch.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  load-use stall; 1 = hold PC and IF/ID.
- flush_i  in  1  branch taken in ID; 1 = squash fetch, redirect PC.
- branch_target_i  in  ADDR_W  redirect address; valid when flush_i=1.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address, always equal to pc.
- imem_ready_i  in  1  imem_rdata_i valid for imem_addr_o this cycle.
- imem_rdata_i  in  32  fetched instruction.
- if_id_pc_o  out  ADDR_W  PC of the instruction in IF/ID.
- if_id_pc4_o  out  ADDR_W  that PC + 4.
- if_id_instr_o  out  32  instruction in IF/ID.
- if_id_valid_o  out  1  1 = real instruction; 0 = bubble.
- fetch_busy_o  out  1  1 = request outstanding and imem_ready_i low.

Behaviour:
- Reset (rst_i=1 at an edge):
  - pc <= RESET_PC; state <= S_FETCH.
  - if_id_pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o <= 0; hold buffer cleared.
  - imem_req_o = 0 while rst_i=1, combinationally.
  - Reset overrides every other input, including mid-fetch and in S_HELD.
- Arithmetic:
  - pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 = 0.
  - branch_target_i[1:0] forced to 0 when loaded.
- Outputs:
  - imem_req_o = (state==S_FETCH) && !rst_i.
  - imem_addr_o = pc.
  - fetch_busy_o = imem_req_o && !imem_ready_i.
- S_FETCH, priority in order:
  1. flush_i: pc <= target; IF/ID valid <= 0 (other fields don't-care); any ready data discarded; stay S_FETCH. Flush beats stall.
  2. stall_i: IF/ID holds; pc holds. If imem_ready_i, capture rdata in the hold buffer and go S_HELD; otherwise stay.
  3. imem_ready_i: IF/ID <= {pc, pc+4, rdata, 1}; pc <= pc+4.
  4. Otherwise (memory wait): IF/ID valid <= 0 (bubble); pc holds.
- S_HELD (imem_req_o=0; hold buffer holds instruction for current pc), priority in order:
  1. flush_i: drop buffer; pc <= target; IF/ID valid <= 0; go S_FETCH.
  2. stall_i: everything holds.
  3. Otherwise: IF/ID <= {pc, pc+4, buffer, 1}; pc <= pc+4; go S_FETCH.
- Latency:
  - Zero-wait memory: one instruction per cycle.
  - Instruction returned in cycle N appears on IF/ID outputs after edge N.
  - Branch redirect: next request uses the target one cycle after flush_i.
- Memory protocol:
  - imem_ready_i refers to the address driven in the same cycle.
  - Changing imem_addr_o (flush) abandons the access.
  - imem_ready_i while imem_req_o=0 is ignored.
- Stall while IF/ID holds a bubble keeps the bubble; stall never creates a valid entry.

Test Plan:
- Reset, then imem_ready_i=1 constantly with rdata = addr ^ 32'hA5A5_0000 → after edges 1..4, if_id_pc_o = 0, 4, 8, C; valid=1 each cycle; if_id_pc4_o = pc+4.
- Memory waits 2 cycles per fetch → valid pattern 0,0,1 repeating; fetch_busy_o high during waits; pc advances only on ready.
- stall_i=1 for 3 cycles in the same cycle ready returns instr 0x8C01_0004 at pc=8 → IF/ID frozen, state S_HELD, imem_req_o=0. After release, IF/ID = {8, C, 0x8C01_0004, 1}; next request addr = C.
- flush_i=1 with target 32'h0000_0103 while stall_i=1 and ready=1 → pc = 0x100; if_id_valid_o=0; next imem_addr_o = 0x100; returned data discarded.
- Flush in S_HELD → buffer dropped and not delivered; next valid instruction has if_id_pc_o = target.
- pc = 32'hFFFF_FFFC fetched → next pc = 0, if_id_pc4_o = 0.
- rst_i asserted in S_HELD mid-stall → next cycle pc = RESET_PC, valid=0, imem_req_o=0 during reset and 1 the cycle after.
